uart_tx_fifo_param: RTL
=======================

Name: uart_tx_fifo_param

Overview:
- Next-generation UART transmitter.
- Generalises the fixed 8-bit, single-word TX to parametrised data width, a runtime baud prescaler, 1 or 2 stop bits, and an input FIFO so frames go back-to-back.
- Sits between the parallel producer (Data_Valid/Data_Ready handshake) and the serial line TX_OUT.
- Parity options unchanged: enable plus even/odd.

Parameters:
- DATA_WIDTH, 8: data bits per frame, legal range 5..9.
- PRESCALE_WIDTH, 16: width of the prescale input.
- FIFO_DEPTH, 4: input FIFO entries. Power of two, ≥2.

Ports:
- CLK  in  1  single clock.
- RST  in  1  asynchronous, active-low reset.
- P_DATA  in  DATA_WIDTH  parallel word to transmit.
- Data_Valid  in  1  producer offers P_DATA.
- Data_Ready  out  1  FIFO can accept a word.
- parity_enable  in  1  1 = append parity bit.
- parity_type  in  1  0 = even, 1 = odd.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- prescale  in  PRESCALE_WIDTH  CLK cycles per bit. 0 is treated as 1.
- TX_OUT  out  1  serial line, idle high.
- busy  out  1  FSM not in IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (RST low, async): TX_OUT=1, busy=0, Data_Ready=0 while asserted, fifo_count=0, FSM=IDLE, FIFO flushed. Data_Ready=1 from the first cycle after release.
- Reset mid-frame: frame aborted; TX_OUT forced to 1 immediately; queued words lost.
- Push: word written on a CLK edge where Data_Valid && Data_Ready.
  - Data_Ready = (fifo_count != FIFO_DEPTH), registered.
  - When full, a push is refused even if a pop occurs the same cycle. Data_Valid without Data_Ready is ignored.
  - P_DATA need not be held after acceptance.
- Pop: FSM pops the head only in IDLE with FIFO non-empty, or at the end of the last stop bit with FIFO non-empty. Push and pop in the same cycle: fifo_count unchanged.
- Config latch: parity_enable, parity_type, stop_bits and prescale are sampled at pop. Changes mid-frame do not affect the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on pop.
  - START → DATA after 1 bit time.
  - DATA → PARITY after DATA_WIDTH bit times if parity enabled, else → STOP.
  - PARITY → STOP after 1 bit time.
  - STOP → START after 1 or 2 bit times if FIFO non-empty (no idle gap), else → IDLE.
- Bit time: a down-counter loaded with max(prescale,1)-1 at each bit start; the bit advances when the counter reaches 0.
- Line values:
  - START drives 0.
  - DATA drives LSB first.
  - PARITY drives ^data for even, ~^data for odd.
  - STOP drives 1.
  - TX_OUT is registered.
- Latency: word pushed into an empty FIFO with the FSM idle at edge N → pop at edge N+1 → TX_OUT=0 after edge N+2.
- Frame length: (1 + DATA_WIDTH + parity_enable + 1 + stop_bits) × max(prescale,1) cycles.
- busy rises with the START-state entry and falls on return to IDLE. busy stays high across back-to-back frames.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- When defined:
  - Adds input send_break (1 bit).
  - send_break sampled high in IDLE enters state BREAK: TX_OUT=0 for (DATA_WIDTH+3)×max(prescale,1) cycles, busy=1, FIFO not popped.
  - After BREAK: one stop bit time at 1, then normal operation.
  - send_break is ignored outside IDLE. If send_break and a pop are both possible in IDLE, BREAK has priority.
- When undefined: no send_break port, no BREAK state. Behaviour is exactly as above.

Test Plan:
1. Reset, then DATA_WIDTH=8, prescale=4, parity off, stop_bits=0, push 0xA5 → TX_OUT sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; busy high 40 cycles, then low.
2. parity_enable=1: push 0x07 with parity_type=0 → parity bit 1; with parity_type=1 → parity bit 0. stop_bits=1 → two stop-bit times; frame = 12×prescale cycles.
3. Push 5 words back-to-back with FIFO_DEPTH=4 while the first is transmitting → Data_Ready drops when fifo_count=4; all 5 words emitted in order with no idle bit between frames; busy never deasserts.
4. prescale=0 → 1 cycle per bit. Change prescale from 4 to 8 mid-frame → current frame keeps 4, next frame uses 8.
5. Assert RST in the middle of the DATA state with 2 words queued → TX_OUT=1 and busy=0 immediately; fifo_count=0; the first push after release transmits normally.
6. (UART_TX_BREAK_EN) send_break in IDLE with prescale=2, DATA_WIDTH=8 → TX_OUT low 22 cycles, high 2 cycles; a word queued during BREAK is sent afterwards.

Source files
------------

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: FIFO-fed UART transmitter with runtime prescale, parity and 1/2 stop bits.
// Defining UART_TX_BREAK_EN adds a send_break input that emits a line break from IDLE.
module uart_tx_fifo_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [DATA_WIDTH-1:0]       P_DATA,
    input  logic                        Data_Valid,
    output logic                        Data_Ready,
    input  logic                        parity_enable,
    input  logic                        parity_type,
    input  logic                        stop_bits,
    input  logic [PRESCALE_WIDTH-1:0]   prescale,
`ifdef UART_TX_BREAK_EN
    input  logic                        send_break,
`endif
    output logic                        TX_OUT,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_BREAK_EN
    localparam logic [3:0] LAST_BREAK = 4'(DATA_WIDTH + 2);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wptr_q, rptr_q;
    logic [AW:0]               count_q, count_d;
    logic                      ready_q, push, pop, brk_req, line, stop_end;
    logic [DATA_WIDTH-1:0]     head, data_q;
    logic [PRESCALE_WIDTH-1:0] presc_in, presc_q, cnt_q;
    logic [3:0]                bit_q;
    logic                      par_q, pen_q, stop2_q, tx_q, busy_q;
    state_t                    state_q;

`ifdef UART_TX_BREAK_EN
    assign brk_req = send_break;
`else
    assign brk_req = 1'b0;
`endif

    assign head     = mem_q[rptr_q];
    assign presc_in = (prescale == '0) ? '0 : prescale - 1'b1;
    assign stop_end = state_q == STOP && cnt_q == '0 && bit_q == {3'b0, stop2_q};
    // A pending break wins over a pop in IDLE
    assign pop      = count_q != '0 && ((state_q == IDLE && !brk_req) || stop_end);
    assign push     = Data_Valid && ready_q;
    assign count_d  = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    assign line     = state_q == DATA ? data_q[0] : state_q == PARITY ? par_q : (state_q == IDLE || state_q == STOP);

    assign Data_Ready = ready_q;
    assign TX_OUT     = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    always_ff @(posedge CLK)
        if (push) mem_q[wptr_q] <= P_DATA;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
            ready_q <= count_d != FULL;
        end
    end

    // Line output is the registered image of the current state, one cycle behind it
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            tx_q <= line;
            if (state_q != IDLE && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            else if (state_q != IDLE) begin
                cnt_q <= presc_q;
                bit_q <= bit_q + 1'b1;
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        bit_q   <= '0;
                    end
                    DATA: begin
                        data_q <= data_q >> 1;
                        if (bit_q == LAST_DATA) begin
                            state_q <= pen_q ? PARITY : STOP;
                            bit_q   <= '0;
                        end
                    end
                    PARITY: begin
                        state_q <= STOP;
                        bit_q   <= '0;
                    end
`ifdef UART_TX_BREAK_EN
                    BREAK: if (bit_q == LAST_BREAK) begin
                        state_q <= STOP;
                        bit_q   <= '0;
                    end
`endif
                    default: if (bit_q == {3'b0, stop2_q}) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
`ifdef UART_TX_BREAK_EN
            if (state_q == IDLE && send_break) begin
                state_q <= BREAK;
                busy_q  <= 1'b1;
                cnt_q   <= presc_in;
                presc_q <= presc_in;
                bit_q   <= '0;
                stop2_q <= 1'b0;
            end
`endif
            if (pop) begin
                state_q <= START;
                busy_q  <= 1'b1;
                data_q  <= head;
                par_q   <= ^head ^ parity_type;
                pen_q   <= parity_enable;
                stop2_q <= stop_bits;
                presc_q <= presc_in;
                cnt_q   <= presc_in;
                bit_q   <= '0;
            end
        end
    end
endmodule
